// File: rtl/ir_gesture_pkg.sv
// Shared types for the IR gesture front end: movement codes, sensor bit positions and the
// pattern classifier.
package ir_gesture_pkg;

    typedef enum logic [3:0] {
        HOVER      = 4'd0,
        FWD        = 4'd1,
        BACK       = 4'd2,
        LEFT       = 4'd3,
        RIGHT      = 4'd4,
        FWD_RIGHT  = 4'd5,
        FWD_LEFT   = 4'd6,
        BACK_RIGHT = 4'd7,
        BACK_LEFT  = 4'd8,
        INVALID    = 4'd9
    } move_code_t;

    localparam int unsigned IR_BACK  = 0;
    localparam int unsigned IR_FWD   = 1;
    localparam int unsigned IR_RIGHT = 2;
    localparam int unsigned IR_LEFT  = 3;

    function automatic move_code_t classify(input logic [3:0] pat);
        move_code_t code;
        if (pat == 4'd0) begin
            code = HOVER;
        end else if ((pat[IR_BACK] & pat[IR_FWD]) | (pat[IR_RIGHT] & pat[IR_LEFT])) begin
            // Opposing sensors both covered; also catches every 3- and 4-bit pattern
            code = INVALID;
        end else begin
            case (pat)
                4'b0010: code = FWD;
                4'b0001: code = BACK;
                4'b1000: code = LEFT;
                4'b0100: code = RIGHT;
                4'b0110: code = FWD_RIGHT;
                4'b1010: code = FWD_LEFT;
                4'b0101: code = BACK_RIGHT;
                4'b1001: code = BACK_LEFT;
                default: code = INVALID;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/ir_gesture_if.sv
// Valid/ready channel carrying movement codes from the gesture conditioner downstream.
interface ir_gesture_if;
    import ir_gesture_pkg::*;

    move_code_t move_code;
    logic       move_valid;
    logic       move_ready;

    modport master (output move_code, output move_valid, input move_ready);
    modport slave  (input move_code, input move_valid, output move_ready);

endinterface

// File: rtl/ir_debounce.sv
// One IR channel: 2-flop synchroniser followed by a counting debouncer. A new level reaches
// the output exactly 2+DEBOUNCE_CYCLES clocks after it appears at the input.
module ir_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The flip happens on the edge the count would reach DEBOUNCE_CYCLES
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/ir_gesture_conditioner.sv
// IR gesture front end: debounces four sensors, qualifies held patterns into movement codes
// and offers them on a valid/ready channel. IR_GESTURE_STATS_EN adds event counters.
module ir_gesture_conditioner
    import ir_gesture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 250000,
    parameter bit          IR_ACTIVE_LOW   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         ir_raw,
    output logic [3:0]         ir_clean,
    ir_gesture_if.master       mv,
    output logic               overrun
`ifdef IR_GESTURE_STATS_EN
    ,
    output logic [15:0]        gesture_count,
    output logic [15:0]        invalid_count
`endif
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [3:0] ir_act;
    assign ir_act = IR_ACTIVE_LOW ? ~ir_raw : ir_raw;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        ir_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (ir_act[i]),
            .dout   (ir_clean[i])
        );
    end

    logic [1:0]    state_q, state_d;
    logic [3:0]    lp_q, lp_d;
    logic [HW-1:0] hc_q, hc_d;
    logic          emit;
    move_code_t    emit_code;

    always_comb begin
        state_d   = state_q;
        lp_d      = lp_q;
        hc_d      = hc_q;
        emit      = 1'b0;
        emit_code = HOVER;
        case (state_q)
            ST_IDLE: begin
                if (ir_clean != 4'd0) begin
                    state_d = ST_ARM;
                    lp_d    = ir_clean;
                    hc_d    = HW'(1);
                end
            end
            ST_ARM: begin
                if (ir_clean == 4'd0) begin
                    state_d = ST_IDLE;
                    hc_d    = '0;
                end else if (ir_clean != lp_q) begin
                    lp_d = ir_clean;
                    hc_d = HW'(1);
                end else begin
                    if (hc_q != HW'(HOLD_CYCLES)) begin
                        hc_d = hc_q + HW'(1);
                    end
                    if (hc_q >= HW'(HOLD_CYCLES - 1)) begin
                        state_d   = ST_ACTIVE;
                        emit      = 1'b1;
                        emit_code = classify(lp_q);
                    end
                end
            end
            ST_ACTIVE: begin
                if (ir_clean == 4'd0) begin
                    state_d = ST_IDLE;
                    hc_d    = '0;
                    emit    = 1'b1;
                end else if (ir_clean != lp_q) begin
                    state_d = ST_ARM;
                    lp_d    = ir_clean;
                    hc_d    = HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            lp_q    <= '0;
            hc_q    <= '0;
        end else begin
            state_q <= state_d;
            lp_q    <= lp_d;
            hc_q    <= hc_d;
        end
    end

    move_code_t code_q;
    logic       valid_q;
    logic       overrun_q;
    logic       accept;

    assign accept = valid_q && mv.move_ready;

    // A fresh emit always wins; it only counts as an overrun if the old one was not taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q    <= HOVER;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (emit) begin
                code_q    <= emit_code;
                valid_q   <= 1'b1;
                overrun_q <= valid_q && !mv.move_ready;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign mv.move_code  = code_q;
    assign mv.move_valid = valid_q;
    assign overrun       = overrun_q;

`ifdef IR_GESTURE_STATS_EN
    logic [15:0] gesture_q, invalid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gesture_q <= '0;
            invalid_q <= '0;
        end else begin
            if (accept && code_q != HOVER && code_q != INVALID && gesture_q != 16'hFFFF) begin
                gesture_q <= gesture_q + 16'd1;
            end
            if (emit && emit_code == INVALID && invalid_q != 16'hFFFF) begin
                invalid_q <= invalid_q + 16'd1;
            end
        end
    end

    assign gesture_count = gesture_q;
    assign invalid_count = invalid_q;
`endif

endmodule

// File: tb/tb_ir_gesture_conditioner.sv
// Directed bench for ir_gesture_conditioner with short debounce/hold windows.
module tb_ir_gesture_conditioner;
    import ir_gesture_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  ir_raw;
    logic [3:0]  ir_clean;
    logic        overrun;
`ifdef IR_GESTURE_STATS_EN
    logic [15:0] gesture_count;
    logic [15:0] invalid_count;
`endif

    ir_gesture_if bus ();

    ir_gesture_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .IR_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir_raw       (ir_raw),
        .ir_clean     (ir_clean),
        .mv           (bus),
        .overrun      (overrun)
`ifdef IR_GESTURE_STATS_EN
        ,
        .gesture_count(gesture_count),
        .invalid_count(invalid_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Passive monitor, sampled mid-cycle
    int         acc_cnt   = 0;
    int         left_cnt  = 0;
    int         ovr_cnt   = 0;
    int         clean_cnt = 0;
    int         ev_cnt    = 0;
    move_code_t last_acc  = HOVER;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.move_valid && bus.move_ready) begin
                acc_cnt++;
                last_acc = bus.move_code;
                if (bus.move_code == LEFT) left_cnt++;
            end
            if (overrun) ovr_cnt++;
            if (ir_clean != 4'd0) clean_cnt++;
            if (bus.move_valid) ev_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold raw pattern until its event is emitted and taken, then release and take the HOVER
    task automatic gesture(input string tag, input logic [3:0] raw, input move_code_t exp);
        ir_raw = raw;
        step(14);
        check_eq({tag, "_valid"}, 32'(bus.move_valid), 32'd1);
        check_eq({tag, "_code"}, 32'(bus.move_code), 32'(exp));
        ir_raw = 4'hF;
        step(7);
        check_eq({tag, "_hover_valid"}, 32'(bus.move_valid), 32'd1);
        check_eq({tag, "_hover_code"}, 32'(bus.move_code), 32'(HOVER));
        step(1);
        check_eq({tag, "_drop"}, 32'(bus.move_valid), 32'd0);
    endtask

    int a0, c0, e0, l0;

    initial begin
        reset_n        = 1'b0;
        ir_raw         = 4'hF;
        bus.move_ready = 1'b1;
        step(3);
        check_eq("rst_clean", 32'(ir_clean), 32'h0);
        check_eq("rst_code", 32'(bus.move_code), 32'(HOVER));
        check_eq("rst_valid", 32'(bus.move_valid), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        step(2);

        // 1: FWD held, exact debounce and hold latency
        a0 = acc_cnt;
        ir_raw = 4'hD;
        step(5);
        check_eq("t1_clean_early", 32'(ir_clean), 32'h0);
        step(1);
        check_eq("t1_clean", 32'(ir_clean), 32'h2);
        step(7);
        check_eq("t1_valid_early", 32'(bus.move_valid), 32'd0);
        step(1);
        check_eq("t1_valid", 32'(bus.move_valid), 32'd1);
        check_eq("t1_code", 32'(bus.move_code), 32'(FWD));
        step(1);
        check_eq("t1_drop", 32'(bus.move_valid), 32'd0);
        check_eq("t1_acc", 32'(acc_cnt - a0), 32'd1);
        ir_raw = 4'hF;
        step(6);
        check_eq("t1_release_clean", 32'(ir_clean), 32'h0);
        step(1);
        check_eq("t1_hover_valid", 32'(bus.move_valid), 32'd1);
        check_eq("t1_hover_code", 32'(bus.move_code), 32'(HOVER));
        step(1);

        // 2: 3-clock glitch ignored; 4-clock pulse flips ir_clean but makes no event
        c0 = clean_cnt;
        e0 = ev_cnt;
        ir_raw = 4'hD;
        step(3);
        ir_raw = 4'hF;
        step(10);
        check_eq("t2_glitch_clean", 32'(clean_cnt - c0), 32'd0);
        ir_raw = 4'hD;
        step(4);
        ir_raw = 4'hF;
        step(2);
        check_eq("t2_pulse_on", 32'(ir_clean), 32'h2);
        step(3);
        check_eq("t2_pulse_hold", 32'(ir_clean), 32'h2);
        step(1);
        check_eq("t2_pulse_off", 32'(ir_clean), 32'h0);
        step(10);
        check_eq("t2_no_event", 32'(ev_cnt - e0), 32'd0);

        // 3: INVALID, then straight to FWD_RIGHT without a HOVER in between
        a0 = acc_cnt;
        ir_raw = 4'hC;
        step(6);
        check_eq("t3_inv_clean", 32'(ir_clean), 32'h3);
        step(8);
        check_eq("t3_inv_valid", 32'(bus.move_valid), 32'd1);
        check_eq("t3_inv_code", 32'(bus.move_code), 32'(INVALID));
        ir_raw = 4'h9;
        step(6);
        check_eq("t3_fr_clean", 32'(ir_clean), 32'h6);
        step(8);
        check_eq("t3_fr_code", 32'(bus.move_code), 32'(FWD_RIGHT));
        check_eq("t3_acc", 32'(acc_cnt - a0), 32'd1);
        step(1);
        check_eq("t3_drop", 32'(bus.move_valid), 32'd0);
        check_eq("t3_acc2", 32'(acc_cnt - a0), 32'd2);
        ir_raw = 4'hF;
        step(8);

        // 4: backpressure; HOVER overwrites a pending FWD
        a0 = acc_cnt;
        bus.move_ready = 1'b0;
        ir_raw = 4'hD;
        step(14);
        check_eq("t4_fwd_code", 32'(bus.move_code), 32'(FWD));
        ir_raw = 4'hF;
        step(6);
        check_eq("t4_held_code", 32'(bus.move_code), 32'(FWD));
        check_eq("t4_no_ovr_yet", 32'(overrun), 32'd0);
        step(1);
        check_eq("t4_hover_code", 32'(bus.move_code), 32'(HOVER));
        check_eq("t4_overrun", 32'(overrun), 32'd1);
        step(1);
        check_eq("t4_overrun_off", 32'(overrun), 32'd0);
        check_eq("t4_still_valid", 32'(bus.move_valid), 32'd1);
        bus.move_ready = 1'b1;
        step(1);
        check_eq("t4_drop", 32'(bus.move_valid), 32'd0);
        check_eq("t4_acc", 32'(acc_cnt - a0), 32'd1);
        check_eq("t4_acc_code", 32'(last_acc), 32'(HOVER));
        check_eq("t4_ovr_cnt", 32'(ovr_cnt), 32'd1);

        // 5: reset while ARM with an event pending
        bus.move_ready = 1'b0;
        ir_raw = 4'hD;
        step(14);
        check_eq("t5_pending", 32'(bus.move_valid), 32'd1);
        ir_raw = 4'h9;
        step(8);
        reset_n = 1'b0;
        #1;
        check_eq("t5_clean", 32'(ir_clean), 32'h0);
        check_eq("t5_valid", 32'(bus.move_valid), 32'd0);
        check_eq("t5_code", 32'(bus.move_code), 32'(HOVER));
        check_eq("t5_overrun", 32'(overrun), 32'd0);
        ir_raw = 4'hF;
        step(2);
        reset_n = 1'b1;
        e0 = ev_cnt;
        c0 = clean_cnt;
        step(50);
        check_eq("t5_no_event", 32'(ev_cnt - e0), 32'd0);
        check_eq("t5_no_clean", 32'(clean_cnt - c0), 32'd0);
        bus.move_ready = 1'b1;

        // 6: three LEFT gestures and one INVALID
`ifdef IR_GESTURE_STATS_EN
        check_eq("t6_gc_rst", 32'(gesture_count), 32'd0);
        check_eq("t6_ic_rst", 32'(invalid_count), 32'd0);
`endif
        l0 = left_cnt;
        gesture("t6_left0", 4'h7, LEFT);
        gesture("t6_left1", 4'h7, LEFT);
        gesture("t6_left2", 4'h7, LEFT);
        gesture("t6_inv", 4'hC, INVALID);
        check_eq("t6_left_acc", 32'(left_cnt - l0), 32'd3);
`ifdef IR_GESTURE_STATS_EN
        check_eq("t6_gesture_count", 32'(gesture_count), 32'd3);
        check_eq("t6_invalid_count", 32'(invalid_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
